// File: rtl/bcd3_seg_scan_pkg.sv
// rtl/bcd3_seg_scan_pkg.sv - shared scan states and segment/digit constants
package bcd3_seg_scan_pkg;

    typedef enum logic [1:0] {
        S_UNI = 2'd0,
        S_TEN = 2'd1,
        S_HUN = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam logic [2:0] AN_UNI = 3'b001;
    localparam logic [2:0] AN_TEN = 3'b010;
    localparam logic [2:0] AN_HUN = 3'b100;
    localparam logic [2:0] AN_OFF = 3'b000;

endpackage

// File: rtl/bcd3_seg_scan_bcd_to_seg7.sv
// rtl/bcd3_seg_scan_bcd_to_seg7.sv - 4-bit code to active-high 7-segment pattern
module bcd_to_seg7
    import bcd3_seg_scan_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        case (code)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd3_seg_scan.sv
// rtl/bcd3_seg_scan.sv - three-digit BCD display scanner with frame snapshot
module bcd3_seg_scan
    import bcd3_seg_scan_pkg::*;
#(
    parameter int SCAN_DIV   = 4,
    parameter int ACTIVE_LOW = 0,
    parameter int BLANK_LZ   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] hun_i,
    input  logic [3:0] ten_i,
    input  logic [3:0] uni_i,
    output logic [6:0] seg_o,
    output logic [2:0] an_o,
    output logic       frame_o
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_POL = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [2:0] AN_POL  = (ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

    logic [PW-1:0] presc;
    scan_state_t   state, state_nxt;
    logic [3:0]    snap_hun, snap_ten, snap_uni;
    logic          load_pending;
    logic          tick, load;
    logic [3:0]    code;
    logic [6:0]    seg_raw, seg_nxt;
    logic [2:0]    an_sel, an_nxt;
    logic          blank;

    assign tick = en && (presc == PRE_MAX);
    // Reload at the first enabled cycle after reset and at every frame wrap
    assign load = (en && load_pending) || (tick && (state == S_HUN));

    always_comb begin
        state_nxt = state;
        code      = snap_uni;
        an_sel    = AN_UNI;
        blank     = 1'b0;
        case (state)
            S_UNI: begin
                state_nxt = S_TEN;
            end
            S_TEN: begin
                state_nxt = S_HUN;
                code      = snap_ten;
                an_sel    = AN_TEN;
                blank     = (BLANK_LZ != 0) && (snap_hun == 4'd0) && (snap_ten == 4'd0);
            end
            S_HUN: begin
                state_nxt = S_UNI;
                code      = snap_hun;
                an_sel    = AN_HUN;
                blank     = (BLANK_LZ != 0) && (snap_hun == 4'd0);
            end
            default: begin
                state_nxt = S_UNI;
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .code (code),
        .seg  (seg_raw)
    );

    assign seg_nxt = (en && !blank) ? seg_raw : SEG_OFF;
    assign an_nxt  = en ? an_sel : AN_OFF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc        <= '0;
            state        <= S_UNI;
            snap_hun     <= 4'd0;
            snap_ten     <= 4'd0;
            snap_uni     <= 4'd0;
            load_pending <= 1'b1;
            seg_o        <= SEG_OFF ^ SEG_POL;
            an_o         <= AN_OFF ^ AN_POL;
            frame_o      <= 1'b0;
        end else begin
            if (tick) begin
                presc <= '0;
                state <= state_nxt;
            end else if (en) begin
                presc <= presc + 1'b1;
            end
            if (load) begin
                snap_hun     <= hun_i;
                snap_ten     <= ten_i;
                snap_uni     <= uni_i;
                load_pending <= 1'b0;
            end
            frame_o <= load;
            seg_o   <= seg_nxt ^ SEG_POL;
            an_o    <= an_nxt ^ AN_POL;
        end
    end

endmodule

// File: tb/tb_bcd3_seg_scan.sv
// tb/tb_bcd3_seg_scan.sv - directed bench for bcd3_seg_scan
module tb_bcd3_seg_scan;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] hun_i, ten_i, uni_i;
    logic [6:0] seg_o, seg_nb, seg_al;
    logic [2:0] an_o, an_nb, an_al;
    logic       frame_o, frame_nb, frame_al;

    int tests = 0;
    int fails = 0;

    bcd3_seg_scan #(.SCAN_DIV(4), .ACTIVE_LOW(0), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .en(en), .hun_i(hun_i), .ten_i(ten_i), .uni_i(uni_i),
        .seg_o(seg_o), .an_o(an_o), .frame_o(frame_o)
    );

    bcd3_seg_scan #(.SCAN_DIV(4), .ACTIVE_LOW(0), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .en(en), .hun_i(hun_i), .ten_i(ten_i), .uni_i(uni_i),
        .seg_o(seg_nb), .an_o(an_nb), .frame_o(frame_nb)
    );

    bcd3_seg_scan #(.SCAN_DIV(4), .ACTIVE_LOW(1), .BLANK_LZ(1)) dut_al (
        .clk(clk), .rst(rst), .en(en), .hun_i(hun_i), .ten_i(ten_i), .uni_i(uni_i),
        .seg_o(seg_al), .an_o(an_al), .frame_o(frame_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks cycles lo..hi of a 12-cycle frame that started with a snapshot load
    task automatic frame_range(input int lo, input int hi,
                               input logic [6:0] mu, input logic [6:0] mt, input logic [6:0] mh,
                               input logic [6:0] nu, input logic [6:0] nt, input logic [6:0] nh);
        logic [6:0] m [3];
        logic [6:0] n [3];
        logic [2:0] a [3];
        m = '{mu, mt, mh};
        n = '{nu, nt, nh};
        a = '{3'b001, 3'b010, 3'b100};
        for (int i = lo; i <= hi; i++) begin
            step();
            chk("seg", seg_o, m[i / 4]);
            chk("an", {4'b0, an_o}, {4'b0, a[i / 4]});
            chk("frame", {6'b0, frame_o}, {6'b0, (i == 11)});
            chk("seg_nb", seg_nb, n[i / 4]);
            chk("seg_al", seg_al, ~m[i / 4]);
            chk("an_al", {4'b0, an_al}, {4'b0, ~a[i / 4]});
        end
    endtask

    task automatic chk_off(input string tag);
        chk({tag, "_seg"}, seg_o, 7'h00);
        chk({tag, "_an"}, {4'b0, an_o}, 7'h00);
        chk({tag, "_frame"}, {6'b0, frame_o}, 7'h00);
        chk({tag, "_seg_nb"}, seg_nb, 7'h00);
        chk({tag, "_seg_al"}, seg_al, 7'h7F);
        chk({tag, "_an_al"}, {4'b0, an_al}, 7'h07);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0;
        hun_i = 4'd1; ten_i = 4'd2; uni_i = 4'd3;
        #2;
        chk_off("reset");
        step(); step();

        rst = 1'b0; en = 1'b1;
        step();
        chk("first_load_frame", {6'b0, frame_o}, 7'h01);
        chk("first_an", {4'b0, an_o}, 7'h01);
        frame_range(1, 11, 7'h4F, 7'h5B, 7'h06, 7'h4F, 7'h5B, 7'h06);
        frame_range(0, 11, 7'h4F, 7'h5B, 7'h06, 7'h4F, 7'h5B, 7'h06);

        hun_i = 4'd0; ten_i = 4'd0; uni_i = 4'd7;
        frame_range(0, 11, 7'h4F, 7'h5B, 7'h06, 7'h4F, 7'h5B, 7'h06);
        frame_range(0, 11, 7'h07, 7'h00, 7'h00, 7'h07, 7'h3F, 7'h3F);

        hun_i = 4'd0; ten_i = 4'd5; uni_i = 4'd0;
        frame_range(0, 11, 7'h07, 7'h00, 7'h00, 7'h07, 7'h3F, 7'h3F);
        frame_range(0, 11, 7'h3F, 7'h6D, 7'h00, 7'h3F, 7'h6D, 7'h3F);

        hun_i = 4'd1; ten_i = 4'd2; uni_i = 4'd3;
        frame_range(0, 11, 7'h3F, 7'h6D, 7'h00, 7'h3F, 7'h6D, 7'h3F);
        frame_range(0, 5, 7'h4F, 7'h5B, 7'h06, 7'h4F, 7'h5B, 7'h06);
        uni_i = 4'd8;
        frame_range(6, 11, 7'h4F, 7'h5B, 7'h06, 7'h4F, 7'h5B, 7'h06);
        frame_range(0, 11, 7'h7F, 7'h5B, 7'h06, 7'h7F, 7'h5B, 7'h06);

        hun_i = 4'd0; ten_i = 4'hA; uni_i = 4'd8;
        frame_range(0, 11, 7'h7F, 7'h5B, 7'h06, 7'h7F, 7'h5B, 7'h06);
        frame_range(0, 11, 7'h7F, 7'h40, 7'h00, 7'h7F, 7'h40, 7'h3F);

        frame_range(0, 5, 7'h7F, 7'h40, 7'h00, 7'h7F, 7'h40, 7'h3F);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_off("en_low");
        end
        en = 1'b1;
        frame_range(6, 11, 7'h7F, 7'h40, 7'h00, 7'h7F, 7'h40, 7'h3F);

        frame_range(0, 8, 7'h7F, 7'h40, 7'h00, 7'h7F, 7'h40, 7'h3F);
        rst = 1'b1;
        #1;
        chk_off("mid_reset");
        hun_i = 4'd4; ten_i = 4'd9; uni_i = 4'd6;
        step();
        rst = 1'b0;
        step();
        chk("reload_frame", {6'b0, frame_o}, 7'h01);
        chk("restart_an", {4'b0, an_o}, 7'h01);
        frame_range(1, 11, 7'h7D, 7'h6F, 7'h66, 7'h7D, 7'h6F, 7'h66);
        frame_range(0, 11, 7'h7D, 7'h6F, 7'h66, 7'h7D, 7'h6F, 7'h66);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd3_seg_scan.md
Name: bcd3_seg_scan

Overview:
Display stage directly downstream of the 000-999 hundreds/tens/units BCD counter. It takes the three 4-bit BCD digits and time-multiplexes them onto one shared 7-segment bus with a one-hot digit-enable bus, scanning units, then tens, then hundreds. A digit snapshot taken once per scan frame prevents tearing. The block also blanks leading zeros and shows a dash for non-BCD codes.

Parameters:
SCAN_DIV, 4, clk cycles each digit is displayed; legal range >= 2.
ACTIVE_LOW, 0, 1 = invert seg_o and an_o (common-anode board); 0 = active-high.
BLANK_LZ, 1, 1 = blank leading zeros on hundreds/tens; 0 = always show all digits.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
en  in  1  scan enable; 0 freezes the scan and blanks the display
hun_i  in  4  hundreds BCD digit from the counter
ten_i  in  4  tens BCD digit
uni_i  in  4  units BCD digit
seg_o  out  7  segments; bit0=a ... bit6=g
an_o  out  3  one-hot digit enable; bit0=units, bit1=tens, bit2=hundreds
frame_o  out  1  single-cycle pulse when a new snapshot is loaded

Behaviour:
- Reset (async, rst=1):
  - prescaler=0, state=S_UNI, snapshot=000, load_pending=1.
  - seg_o and an_o are all-off: 0 when ACTIVE_LOW=0, all-ones when ACTIVE_LOW=1.
  - frame_o=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 only while en=1. tick = (en && prescaler==SCAN_DIV-1); the prescaler wraps to 0 on tick.
  - en=0 holds the prescaler and state.
- Scan FSM, advancing only on tick:
  - S_UNI -> S_TEN -> S_HUN -> S_UNI.
  - Frame = 3*SCAN_DIV enabled cycles.
- Snapshot load (loads {hun_i,ten_i,uni_i}):
  - (a) on the first cycle with en=1 while load_pending=1, which then clears load_pending; or
  - (b) on the tick that moves S_HUN -> S_UNI.
  - frame_o=1 (registered) in the cycle after a load.
  - Input changes between loads are not displayed.
- Display value:
  - Combinational digit select from state and snapshot: S_UNI=units, S_TEN=tens, S_HUN=hundreds.
  - seg_o and an_o are registered, so they reflect the state one cycle later; latency from state change to pins is 1 cycle.
  - While en=0, the output register loads all-off on the next edge.
- Segment encoding, active-high hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes A-F show a dash = 40.
- Leading-zero blanking (BLANK_LZ=1):
  - Hundreds is blanked (seg 00) when snap_hun==0.
  - Tens is blanked when snap_hun==0 and snap_ten==0.
  - Units is never blanked.
  - A non-BCD code counts as non-zero.
  - A blanked digit still drives its an_o bit; only the segments go off.
- ACTIVE_LOW=1 inverts the final seg_o and an_o, including the reset and all-off values.
- Simultaneous events:
  - A tick and a pending first load in the same cycle: both take effect.
  - rst mid-frame: immediate async return to the reset state; the next frame restarts at S_UNI with a fresh load.

Decomposition:
- Shared package holds:
  - scan-state encoding S_UNI/S_TEN/S_HUN (2-bit);
  - SEG_DASH=7'h40 and SEG_OFF=7'h00;
  - the digit-enable one-hot constants.
- One sub-module, bcd_to_seg7: purely combinational 4-bit code -> 7-bit active-high segments, with dash for A-F. Polarity inversion and blanking stay in the parent.

Test Plan:
1. Reset values: assert rst, check seg_o=00, an_o=000, frame_o=0 (ACTIVE_LOW=0). Release, en=1, inputs 1/2/3 -> frame_o pulses once. Each scan cycle shows:
   - an_o=001 with seg_o=4F for 4 cycles;
   - then an_o=010 with seg_o=5B;
   - then an_o=100 with seg_o=06.
2. Blanking: inputs 0/0/7 -> hundreds and tens slots show seg_o=00 with an_o still asserted; units shows 07. Inputs 0/5/0 -> hundreds 00, tens 6D, units 3F. With BLANK_LZ=0, inputs 0/0/7 -> hundreds and tens show 3F.
3. Snapshot: change uni_i from 3 to 8 during S_TEN -> units keeps showing 4F until after the next S_HUN->S_UNI tick, then shows 7F. frame_o pulses exactly once per 12 cycles.
4. Invalid code: ten_i=4'hA with hun_i=0 -> tens slot shows 40 (not blanked); hundreds slot shows 00.
5. Enable and polarity: drop en for 5 cycles mid-frame -> outputs go all-off the next cycle, and the scan resumes from the same state and prescaler value. With ACTIVE_LOW=1 the reset values are seg_o=7F and an_o=111, and the units slot showing 3 is an_o=110, seg_o=30.
6. Reset mid-operation: assert rst during S_HUN -> outputs go all-off in the same cycle. After release, the scan restarts at the units slot with a new snapshot and a frame_o pulse.
